// File: rtl/dm_pkg.sv
// dm_pkg: shared state type, widths and address helpers for the data-memory responder
package dm_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dm_state_e;
  localparam int BE_W = 4;
  localparam int LAT_W = 4;
  function automatic logic [29:0] word_addr(input logic [31:0] a);
    return a[31:2];
  endfunction
  function automatic logic in_range(input logic [31:0] a, input int aw);
    return (a >> (aw + 2)) == 32'd0;
  endfunction
endpackage

// File: rtl/dm_sram_array.sv
// dm_sram_array: word-organised single-port SRAM, synchronous byte-enabled write, no reset
//   clk      rising-edge clock
//   i_we     write strobe for the addressed word
//   i_addr   word address
//   i_be     per-lane write enables (bit i -> byte lane i)
//   i_wdata  write data
//   o_rdata  word at i_addr, sampled by the caller on its commit edge
module dm_sram_array import dm_pkg::*; #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [BE_W-1:0]   i_be,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);
  logic [31:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (i_we)
      for (int i = 0; i < BE_W; i++)
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/dm_responder.sv
// dm_responder: one-outstanding load/store responder with programmable wait states
//   clk/reset             clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we/addr/be/wdata  request payload, latched on accept
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata/rsp_err     load data (0 for stores/errors), out-of-range flag
module dm_responder import dm_pkg::*; #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [BE_W-1:0] req_be,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
);
  if (LATENCY < 0 || LATENCY > 15) begin : g_lat_chk
    $error("dm_responder: LATENCY must be within 0..15");
  end
  dm_state_e r_state, w_next;
  logic [LAT_W-1:0] r_cnt, w_lat;
  logic r_we, r_err, w_accept, w_commit, w_we, w_in, w_wr;
  logic [31:0] r_addr, r_wdata, r_rdata, w_addr, w_wdata, w_mem_rdata;
  logic [BE_W-1:0] r_be, w_be;
  logic [29:0] w_word;
  assign w_lat = LAT_W'(LATENCY == 0 ? 0 : LATENCY - 1);
  assign w_accept = r_state == IDLE && req_valid;
  assign w_commit = (w_accept && LATENCY == 0) || (r_state == WAIT && r_cnt == '0);
  // zero-latency commits on the accept edge, before the latched copy exists
  assign w_we = r_state == IDLE ? req_we : r_we;
  assign w_addr = r_state == IDLE ? req_addr : r_addr;
  assign w_be = r_state == IDLE ? req_be : r_be;
  assign w_wdata = r_state == IDLE ? req_wdata : r_wdata;
  assign w_word = word_addr(w_addr);
  assign w_in = in_range(w_addr, ADDR_W);
  assign w_wr = w_commit && w_we && w_in;
  dm_sram_array #(.ADDR_W(ADDR_W)) u_sram (
    .clk(clk),
    .i_we(w_wr),
    .i_addr(w_word[ADDR_W-1:0]),
    .i_be(w_be),
    .i_wdata(w_wdata),
    .o_rdata(w_mem_rdata)
  );
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && req_valid) w_next = LATENCY == 0 ? RESP : WAIT;
    else if (r_state == WAIT && r_cnt == '0) w_next = RESP;
    else if (r_state == RESP && rsp_ready) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rdata <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_cnt <= w_lat;
      else if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_commit) begin
        r_rdata <= w_in && !w_we ? w_mem_rdata : 32'd0;
        r_err <= !w_in;
      end
    end
  always_ff @(posedge clk)
    if (w_accept) begin
      r_we <= req_we;
      r_addr <= req_addr;
      r_be <= req_be;
      r_wdata <= req_wdata;
    end
  assign req_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign rsp_rdata = r_rdata;
  assign rsp_err = r_err;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: random and directed checks of dm_responder (LATENCY 2 and 0) against a behavioural model
module tb_dm_responder;
  logic clk = 1'b0, reset = 1'b0;
  logic req_valid[2], req_ready[2], req_we[2], rsp_valid[2], rsp_ready[2], rsp_err[2];
  logic [31:0] req_addr[2], req_wdata[2], rsp_rdata[2];
  logic [3:0] req_be[2];
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dm_responder #(.ADDR_W(12), .LATENCY(2)) u_lat2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );
  dm_responder #(.ADDR_W(12), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h at t=%0t", name, act, exp, $time);
    end
  endtask
  int lat[2] = '{2, 0};
  bit pend[2], comm[2], known[2], m_we[2], exp_err[2];
  int due[2];
  logic [31:0] m_addr[2], m_wd[2], exp_rd[2];
  logic [3:0] m_be[2];
  bit [31:0] mdl[int];
  task automatic commit(input int k);
    int key;
    bit [31:0] w;
    key = (k << 20) | int'(m_addr[k][13:2]);
    comm[k] = 1'b1;
    known[k] = 1'b1;
    exp_rd[k] = 32'd0;
    exp_err[k] = m_addr[k][31:14] != 18'd0;
    if (!exp_err[k]) begin
      if (m_we[k]) begin
        if (mdl.exists(key)) begin
          w = mdl[key];
          for (int i = 0; i < 4; i++) if (m_be[k][i]) w[8*i +: 8] = m_wd[k][8*i +: 8];
          mdl[key] = w;
        end else if (m_be[k] == 4'hF) mdl[key] = m_wd[k];
      end else begin
        known[k] = mdl.exists(key);
        if (known[k]) exp_rd[k] = mdl[key];
      end
    end
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pend[k] && !comm[k] && cyc == due[k]) commit(k);
      if (!reset) pend[k] = 1'b0;
      chk($sformatf("req_ready dut%0d", k), 32'(req_ready[k]), 32'(!pend[k]));
      chk($sformatf("rsp_valid dut%0d", k), 32'(rsp_valid[k]), 32'(pend[k] && comm[k]));
      if (pend[k] && comm[k]) begin
        chk($sformatf("rsp_err dut%0d", k), 32'(rsp_err[k]), 32'(exp_err[k]));
        if (known[k]) chk($sformatf("rsp_rdata dut%0d", k), rsp_rdata[k], exp_rd[k]);
      end
      if (reset) begin
        if (pend[k]) begin
          if (comm[k] && rsp_ready[k]) pend[k] = 1'b0;
        end else if (req_valid[k]) begin
          pend[k] = 1'b1;
          comm[k] = 1'b0;
          due[k] = cyc + 1 + lat[k];
          m_we[k] = req_we[k];
          m_addr[k] = req_addr[k];
          m_be[k] = req_be[k];
          m_wd[k] = req_wdata[k];
        end
      end
    end
  end
  task automatic txn(input int k, input bit we, input logic [31:0] a, input logic [3:0] be,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic err, output int t0, output int le);
    int n;
    n = 0;
    req_valid[k] = 1'b1;
    req_we[k] = we;
    req_addr[k] = a;
    req_be[k] = be;
    req_wdata[k] = wd;
    rsp_ready[k] = hold == 0;
    while (!req_ready[k] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    t0 = cyc;
    req_valid[k] = 1'b0;
    req_we[k] = 1'($urandom);
    req_addr[k] = $urandom;
    req_be[k] = 4'($urandom);
    req_wdata[k] = $urandom;
    while (!rsp_valid[k] && n < 50) begin @(posedge clk); #1; n++; end
    le = cyc - t0;
    rd = rsp_rdata[k];
    err = rsp_err[k];
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL handshake timeout dut%0d: actual no response required response within 50 cycles", k);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold rsp_valid", 32'(rsp_valid[k]), 32'd1);
      chk("hold req_ready", 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk); #1;
    chk("idle after handshake rsp_valid", 32'(rsp_valid[k]), 32'd0);
    chk("idle after handshake req_ready", 32'(req_ready[k]), 32'd1);
  endtask
  initial begin : watchdog
    #1000000;
    $display("FAIL global timeout: actual still running required finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] rd;
    logic err;
    int t0, le, prev, saw;
    logic [31:0] vals[4];
    vals = '{32'hA5A5_0001, 32'h0F0F_1234, 32'h8000_0007, 32'hCAFE_F00D};
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0; req_be[k] = '0;
      req_wdata[k] = '0; rsp_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    txn(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd, err, t0, le);
    chk("store err", 32'(err), 32'd0);
    chk("store rdata", rd, 32'd0);
    txn(0, 0, 32'h10, 4'h0, 32'h0, 0, rd, err, t0, le);
    chk("load 0x10 rdata", rd, 32'hDEADBEEF);
    chk("load 0x10 err", 32'(err), 32'd0);
    chk("lat2 response edges", 32'(le), 32'd2);
    txn(0, 1, 32'h20, 4'hF, 32'h11223344, 0, rd, err, t0, le);
    txn(0, 1, 32'h22, 4'b0101, 32'hAABBCCDD, 0, rd, err, t0, le);
    txn(0, 0, 32'h20, 4'h0, 32'h0, 0, rd, err, t0, le);
    chk("byte-lane merge", rd, 32'h11BB33DD);
    txn(0, 1, 32'h0, 4'hF, 32'h12345678, 0, rd, err, t0, le);
    txn(0, 0, 32'h0001_0000, 4'h0, 32'h0, 0, rd, err, t0, le);
    chk("oor load err", 32'(err), 32'd1);
    chk("oor load rdata", rd, 32'd0);
    txn(0, 1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, 0, rd, err, t0, le);
    chk("oor store err", 32'(err), 32'd1);
    txn(0, 0, 32'h0, 4'h0, 32'h0, 0, rd, err, t0, le);
    chk("word 0 after oor store", rd, 32'h12345678);
    txn(0, 0, 32'h10, 4'h0, 32'h0, 5, rd, err, t0, le);
    chk("held load rdata", rd, 32'hDEADBEEF);
    txn(0, 1, 32'h20, 4'h0, 32'h0, 0, rd, err, t0, le);
    chk("be0 store err", 32'(err), 32'd0);
    txn(0, 0, 32'h20, 4'h0, 32'h0, 0, rd, err, t0, le);
    chk("be0 store leaves word", rd, 32'h11BB33DD);
    txn(0, 1, 32'h30, 4'hF, 32'h01010101, 0, rd, err, t0, le);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h30; req_be[0] = 4'hF;
    req_wdata[0] = 32'h5555AAAA;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    reset = 1'b0;
    saw = 0;
    repeat (3) begin @(posedge clk); #1; saw |= int'(rsp_valid[0]); end
    reset = 1'b1;
    repeat (4) begin @(posedge clk); #1; saw |= int'(rsp_valid[0]); end
    chk("rsp_valid after mid-wait reset", 32'(saw), 32'd0);
    txn(0, 0, 32'h30, 4'h0, 32'h0, 0, rd, err, t0, le);
    chk("aborted store not committed", rd, 32'h01010101);
    for (int i = 0; i < 4; i++) txn(1, 1, 32'h40 + 4 * i, 4'hF, vals[i], 0, rd, err, t0, le);
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      txn(1, 0, 32'h40 + 4 * i, 4'h0, 32'h0, 0, rd, err, t0, le);
      chk($sformatf("lat0 load %0d rdata", i), rd, vals[i]);
      chk("lat0 response edges", 32'(le), 32'd0);
      if (i > 0) chk("lat0 accept spacing", 32'(t0 - prev), 32'd2);
      prev = t0;
    end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) txn(k, 1, 32'h100 + 4 * i, 4'hF, $urandom, 0, rd, err, t0, le);
    for (int n = 0; n < 300; n++) begin
      int k;
      logic [31:0] a;
      k = int'($urandom_range(0, 1));
      a = $urandom_range(0, 7) == 0 ? ($urandom | 32'h0004_0000)
                                      : 32'h100 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
      txn(k, 1'($urandom), a, 4'($urandom), $urandom, int'($urandom_range(0, 3)), rd, err, t0, le);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
